// File: rtl/seq_addsub_unit.sv
// Digit-serial adder/subtractor: WIDTH-bit A+B or A-B, DIGIT bits per cycle, LSB first.
// Latency: out_valid rises N = WIDTH/DIGIT clock edges after the accepting edge.
// Backpressure: the result and flags are held in DONE until out_ready; in_ready=0 while busy.
// Optional feature: define SEQ_ADDSUB_SAT_EN to saturate S on signed overflow.
module seq_addsub_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cout_q, cout_d;
  logic               v_q, v_d;
  logic               z_q, z_d;

  // Digit datapath signals
  logic [DIGIT:0]     dsum;
  logic [WIDTH-1:0]   s_ins;
  logic [WIDTH-1:0]   s_fin;
  logic               last_digit;
  logic               cin_msb;
  logic               v_calc;

  // Add the current digit of A and captured B with the carry; splice it into the partial result
  always_comb begin
    dsum       = {1'b0, a_q[int'(cnt_q)*DIGIT +: DIGIT]}
               + {1'b0, b_q[int'(cnt_q)*DIGIT +: DIGIT]}
               + {{DIGIT{1'b0}}, carry_q};
    s_ins      = s_q;
    s_ins[int'(cnt_q)*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
    last_digit = (cnt_q == CNT_W'(N - 1));
    // Carry into the MSB recovered from the MSB sum bit; only meaningful on the last digit
    cin_msb    = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_ins[WIDTH-1];
    v_calc     = cin_msb ^ dsum[DIGIT];
    s_fin      = s_ins;
`ifdef SEQ_ADDSUB_SAT_EN
    // Both effective operands share a sign on overflow; that sign picks the clamp direction
    if (v_calc) begin
      s_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub;
          cnt_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          v_d     = 1'b0;
          z_d     = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d     = s_ins;
        carry_d = dsum[DIGIT];
        if (last_digit) begin
          s_d     = s_fin;
          cout_d  = dsum[DIGIT];
          v_d     = v_calc;
          z_d     = (s_fin == '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign S         = s_q;
  assign Cout      = cout_q;
  assign V         = v_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Randomized bench: three units (DIGIT=4, 16, 1) run the same operations against an arithmetic model.
// Checks reset values, result/flags, exact latency, hold under backpressure and async reset abort.
// Honours SEQ_ADDSUB_SAT_EN in the reference model.
module tb_seq_addsub_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a_i = '0;
  logic [15:0] b_i = '0;
  logic        sub_i = 1'b0;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  cout_o;
  logic [2:0]  v_o;
  logic [2:0]  z_o;
  logic [15:0] s_o [3];

  int n_checks = 0;
  int n_err    = 0;
  int lat_exp [3] = '{4, 1, 16};

  always #5 clk = ~clk;

  seq_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .A(a_i), .B(b_i), .sub(sub_i), .out_valid(out_valid[0]), .out_ready(out_ready),
    .S(s_o[0]), .Cout(cout_o[0]), .V(v_o[0]), .Z(z_o[0]));

  seq_addsub_unit #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .A(a_i), .B(b_i), .sub(sub_i), .out_valid(out_valid[1]), .out_ready(out_ready),
    .S(s_o[1]), .Cout(cout_o[1]), .V(v_o[1]), .Z(z_o[1]));

  seq_addsub_unit #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
    .A(a_i), .B(b_i), .sub(sub_i), .out_valid(out_valid[2]), .out_ready(out_ready),
    .S(s_o[2]), .Cout(cout_o[2]), .V(v_o[2]), .Z(z_o[2]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference result {Cout, V, Z, S} from integer arithmetic
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    int          sa, sb, r;
    logic [16:0] full;
    logic [15:0] res;
    logic        c, v;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    full = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    c    = s ? (a >= b) : full[16];
    r    = s ? (sa - sb) : (sa + sb);
    v    = (r > 32767) || (r < -32768);
    res  = full[15:0];
`ifdef SEQ_ADDSUB_SAT_EN
    if (v) res = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {c, v, (res == 16'h0000), res};
  endfunction

  task automatic wait_ready();
    int waited = 0;
    while (in_ready !== 3'b111 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_before_accept", 32'(in_ready), 32'h7);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold);
    logic [18:0] e;
    int          lat [3];
    bit          seen [3];
    bit          all_seen;
    e = model(a, b, s);
    wait_ready();
    a_i = a; b_i = b; sub_i = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_i = 16'($urandom); b_i = 16'($urandom); sub_i = 1'($urandom);
    check("busy_flags", {29'd0, in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin lat[i] = 0; seen[i] = 1'b0; end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      all_seen = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (!seen[i] && out_valid[i]) begin seen[i] = 1'b1; lat[i] = c; end
        all_seen &= seen[i];
      end
      if (all_seen) break;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("latency[%0d]", i), 32'(lat[i]), 32'(lat_exp[i]));
      check($sformatf("S[%0d] %h%s%h", i, a, s ? "-" : "+", b), 32'(s_o[i]), 32'(e[15:0]));
      check($sformatf("CVZ[%0d] %h%s%h", i, a, s ? "-" : "+", b),
            {29'd0, cout_o[i], v_o[i], z_o[i]}, {29'd0, e[18:16]});
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a_i = 16'($urandom); b_i = 16'($urandom); sub_i = 1'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_handshake", {26'd0, out_valid, in_ready}, 32'h38);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("hold_S[%0d]", i), 32'(s_o[i]), 32'(e[15:0]));
        check($sformatf("hold_CVZ[%0d]", i), {29'd0, cout_o[i], v_o[i], z_o[i]}, {29'd0, e[18:16]});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after_release", {26'd0, out_valid, in_ready}, 32'h07);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_hs"}, {26'd0, out_valid, in_ready}, 32'h07);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_S[%0d]", tag, i), 32'(s_o[i]), 32'h0);
      check($sformatf("%s_CVZ[%0d]", tag, i), {29'd0, cout_o[i], v_o[i], z_o[i]}, 32'h0);
    end
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] corners [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin
    int ov_cnt;
    #1 rst = 1'b1;
    #2 check_cleared("reset");
    repeat (2) @(posedge clk);
    #5 rst = 1'b0;

    // Directed cases, then a held-result case
    run_op(16'h0003, 16'h0005, 1'b0, 0);
    run_op(16'h0005, 16'h0005, 1'b1, 0);
    run_op(16'h0000, 16'h0001, 1'b1, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 0);
    run_op(16'h1234, 16'h5678, 1'b0, 3);

    // Reset during RUN cycle 2 aborts the operation in every unit
    wait_ready();
    a_i = 16'hABCD; b_i = 16'h1357; sub_i = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1 check_cleared("async_reset");
    repeat (2) @(posedge clk);
    #5 rst = 1'b0;
    ov_cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid != 3'b000) ov_cnt++;
    end
    check("no_out_after_abort", 32'(ov_cnt), 32'h0);
    run_op(16'h1234, 16'h1111, 1'b0, 0);

    // Randomized operations with occasional backpressure
    for (int k = 0; k < 40; k++) begin
      run_op(pick(), pick(), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_addsub_unit.md
SEQ_ADDSUB_UNIT -- requirements
Module: seq_addsub_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, and DIGIT SHALL be at least 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand request valid.
REQ-006 SHALL have port in_ready, output, 1: unit can accept operands.
REQ-007 SHALL have port A, input, WIDTH: first operand.
REQ-008 SHALL have port B, input, WIDTH: second operand.
REQ-009 SHALL have port sub, input, 1: 0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid, output, 1: result valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port S, output, WIDTH: result.
REQ-013 SHALL have port Cout, output, 1: carry out of the MSB (for sub, 1 = no borrow).
REQ-014 SHALL have port V, output, 1: two's-complement signed overflow.
REQ-015 SHALL have port Z, output, 1: result equals zero.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DONE.
REQ-017 In IDLE: in_ready=1 and out_valid=0; on in_valid&&in_ready, SHALL capture A, B (inverted when sub=1) and sub, set carry register = sub, clear digit counter, and go to RUN.
REQ-018 In RUN: each cycle, SHALL add digit k (LSB first) of A and of the captured B plus the carry register, write DIGIT result bits into S[k], and update the carry register; N = WIDTH/DIGIT cycles total.
REQ-019 After digit N-1, SHALL go to DONE; out_valid SHALL rise exactly N clock edges after the accepting edge (N=1 when DIGIT=WIDTH).
REQ-020 Cout SHALL be the final carry; V SHALL be the XOR of the carry into the MSB and the carry out of it; Z SHALL be 1 iff final S==0; all flags SHALL be valid only while out_valid=1.
REQ-021 In DONE: S, Cout, V and Z SHALL be held stable while out_ready=0; on out_valid&&out_ready, SHALL go to IDLE, and in_ready SHALL rise on the following cycle (no same-cycle re-accept).
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid and operand changes SHALL be ignored there.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH, and S SHALL wrap on overflow (but see REQ-027).

Reset
REQ-024 While rst=1, independent of clk: state=IDLE, in_ready=1, out_valid=0, S=0, Cout=0, V=0, Z=0, counter and carry cleared.
REQ-025 Reset asserted mid-RUN or mid-DONE SHALL abort the operation, and no result SHALL be emitted for it; the first accept is possible on the first rising edge after rst deasserts.

Configuration
REQ-026 Macro SEQ_ADDSUB_SAT_EN SHALL select saturation.
REQ-027 With SEQ_ADDSUB_SAT_EN defined, when V=1 S SHALL saturate to 0x7F..F (positive overflow) or 0x80..0 (negative overflow), V SHALL still report 1, and Z SHALL reflect the saturated S; without the macro, S SHALL wrap per REQ-023.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-028 A=0x0003, B=0x0005, sub=0 -> S=0x0008, Cout=0, V=0, Z=0; out_valid exactly 4 edges after accept.
REQ-029 A=0x0005, B=0x0005, sub=1 -> S=0x0000, Cout=1, V=0, Z=1; A=0x0000, B=0x0001, sub=1 -> S=0xFFFF, Cout=0, V=0.
REQ-030 A=0x7FFF, B=0x0001, sub=0 -> V=1, S=0x8000 (macro off) or S=0x7FFF (macro on); A=0x8000, B=0x0001, sub=1 -> V=1, S=0x7FFF (off) or S=0x8000 (on).
REQ-031 Hold out_ready=0 for 3 cycles in DONE and pulse in_valid with new operands -> S and flags stable, in_ready=0, new operands ignored; pull out_ready=1 -> IDLE, and in_ready=1 on the next cycle.
REQ-032 Assert rst during RUN cycle 2 -> outputs zero immediately (asynchronously), no out_valid; after release, A=0x1234, B=0x1111, sub=0 -> S=0x2345.
REQ-033 Repeat REQ-028 with DIGIT=16 (N=1) and DIGIT=1 (N=16) -> identical results, with latency 1 and 16 respectively.
